// File: rtl/psum_pack_16.sv
// Ping-pong packer that assembles LANES-wide FP16 beats into 16-element
// vectors for the accumulation tree, zero-padding groups closed early by in_last.
module psum_pack_16 #(
  parameter int LANES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*16-1:0]   in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [255:0]          out_vec,
  output logic [4:0]            out_cnt
);

  localparam int BEATS  = 16 / LANES;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  generate
    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
      $error("psum_pack_16: LANES must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  logic [255:0]      slot_vec [2];
  logic [4:0]        slot_cnt [2];
  logic              wr_sel;
  logic              rd_sel;
  logic [1:0]        occ;
  logic [BEAT_W-1:0] beat;

  logic accept;
  logic close;
  logic emit;

  // Handshake qualifiers depend only on registered state (plus reset), so
  // there is no combinational path from out_ready to in_ready.
  assign in_ready  = rst_n && (occ != 2'd2);
  assign out_valid = rst_n && (occ != 2'd0);
  assign accept    = in_valid && in_ready;
  assign close     = accept && ((beat == LAST_BEAT) || in_last);
  assign emit      = out_valid && out_ready;

  assign out_vec = slot_vec[rd_sel];
  assign out_cnt = slot_cnt[rd_sel];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the slot storage is cleared as well, so a vector abandoned by
      // reset can never reappear on out_vec and the outputs read 0 afterwards.
      for (int s = 0; s < 2; s++) begin
        slot_vec[s] <= '0;
        slot_cnt[s] <= '0;
      end
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      occ    <= 2'd0;
      beat   <= '0;
    end else begin
      // NOTE: non-blocking updates mean every test below sees pre-edge state,
      // e.g. padding and the count use the beat index of the closing beat.
      if (accept) begin
        for (int e = 0; e < 16; e++) begin
          if (BEAT_W'(e / LANES) == beat)
            slot_vec[wr_sel][e*16 +: 16] <= in_data[(e % LANES)*16 +: 16];
          else if (close && (BEAT_W'(e / LANES) > beat))
            slot_vec[wr_sel][e*16 +: 16] <= 16'h0000;
        end
        if (close) begin
          slot_cnt[wr_sel] <= 5'((32'(beat) + 1) * LANES);
          beat             <= '0;
          wr_sel           <= ~wr_sel;
        end else begin
          beat <= beat + 1'b1;
        end
      end

      if (emit)
        rd_sel <= ~rd_sel;

      // A close and a handshake in the same cycle cancel out in occ.
      if (close && !emit)
        occ <= occ + 2'd1;
      else if (!close && emit)
        occ <= occ - 2'd1;
    end
  end

endmodule
